// File: rtl/board_display_pkg.sv
// Shared constants for the board display: digit/cell geometry and
// seven-segment glyphs (bit 0 = segment a .. bit 6 = segment g).
package board_disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int CELL_W     = 3;
    localparam int NUM_CELLS  = 4;
    localparam int BCD_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/board_display_seg7_decode.sv
// Combinational 4-bit value to seven-segment glyph; values above 9 are blank.
module seg7_decode
    import board_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    // Decimal glyph lookup
    always_comb begin
        glyph = SEG_BLANK;
        case (value)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/board_display.sv
// Eight-digit multiplexed display of the game board (digits 0-3, with the
// cells changed by the last move blinking) and a saturating BCD move
// counter (digits 4-7).
module board_display
    import board_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_LEN = 4096,
    parameter int BLINK_BIT = 8
) (
    input  logic        clk,
    input  logic        rst_sw,
    input  logic [11:0] board,
    input  logic        ji_mode,
    input  logic        clr,
    input  logic        win,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_LEN);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_LEN - 1);
    localparam logic [3:0]         BCD_NINE   = 4'd9;

    logic [11:0]                board_q;
    logic                       ji_q;
    logic [BCD_DIGITS-1:0][3:0] cnt;
    logic [BCD_DIGITS-1:0][3:0] cnt_inc;
    logic [BCD_DIGITS:0]        carry;
    logic                       cnt_full;
    logic [NUM_CELLS-1:0]       mask;
    logic [NUM_CELLS-1:0]       cell_chg;
    logic [BLINK_W-1:0]         blink_cnt;
    logic [SCAN_W-1:0]          scan_cnt;
    logic [2:0]                 idx;
    logic                       move;
    logic [CELL_W-1:0]          cell_q [NUM_CELLS];
    logic [3:0]                 disp_val;
    logic                       blank;
    logic [6:0]                 glyph;
    logic [7:0]                 seg_next;

    // Per-cell view of the registered board and which cells differ from it
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
        assign cell_q[gi]   = board_q[gi*CELL_W +: CELL_W];
        assign cell_chg[gi] = (board[gi*CELL_W +: CELL_W] != cell_q[gi]);
    end

    // Ripple-carry BCD increment; carry out of the top digit means 9999
    assign carry[0] = 1'b1;
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_bcd
        assign cnt_inc[gi]  = !carry[gi]           ? cnt[gi] :
                              (cnt[gi] == BCD_NINE) ? 4'd0    : cnt[gi] + 4'd1;
        assign carry[gi+1]  = carry[gi] && (cnt[gi] == BCD_NINE);
    end
    assign cnt_full = carry[BCD_DIGITS];

    // ji_q suppresses the cycle where ji_mode drops and the real board returns
    assign move = (board != board_q) && !ji_mode && !ji_q && !clr;

    // Change-detect registers
    always_ff @(posedge clk or posedge rst_sw) begin
        if (rst_sw) begin
            board_q <= '0;
            ji_q    <= 1'b0;
        end else begin
            board_q <= board;
            ji_q    <= ji_mode;
        end
    end

    // Move counter: clear on clr, saturating increment on a move
    always_ff @(posedge clk or posedge rst_sw) begin
        if (rst_sw) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (move && !cnt_full) begin
            cnt <= cnt_inc;
        end
    end

    // Blink mask and timer: a move replaces the mask and restarts the timer
    always_ff @(posedge clk or posedge rst_sw) begin
        if (rst_sw) begin
            mask      <= '0;
            blink_cnt <= '0;
        end else if (clr) begin
            mask      <= '0;
            blink_cnt <= '0;
        end else if (move) begin
            mask      <= cell_chg;
            blink_cnt <= BLINK_LOAD;
        end else if (blink_cnt != '0) begin
            blink_cnt <= blink_cnt - 1'b1;
            if (blink_cnt == BLINK_W'(1)) begin
                mask <= '0;
            end
        end else begin
            mask <= '0;
        end
    end

    // Digit scan: hold each digit SCAN_DIV cycles, then step to the next
    always_ff @(posedge clk or posedge rst_sw) begin
        if (rst_sw) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Select the value shown on the current digit and decide blanking
    always_comb begin
        disp_val = 4'd0;
        blank    = 1'b0;
        if (!idx[2]) begin
            disp_val = {1'b0, cell_q[idx[1:0]]};
            blank    = (cell_q[idx[1:0]] == '0) ||
                       (mask[idx[1:0]] && (blink_cnt != '0) && blink_cnt[BLINK_BIT]);
        end else begin
            disp_val = cnt[idx[1:0]];
        end
        seg_next = {win & ~idx[2], blank ? SEG_BLANK : glyph};
    end

    seg7_decode u_decode (
        .value (disp_val),
        .glyph (glyph)
    );

    // Registered pin drivers, one cycle behind idx and display state
    always_ff @(posedge clk or posedge rst_sw) begin
        if (rst_sw) begin
            seg <= '0;
            an  <= '0;
        end else begin
            seg <= seg_next;
            an  <= 8'b1 << idx;
        end
    end

endmodule

// File: tb/tb_board_display.sv
// Self-checking bench for board_display with a small cycle model built from
// plain integers (move count as a number, blink timer as an int).
module tb_board_display;

    logic        clk = 1'b0;
    logic        rst_sw;
    logic [11:0] board;
    logic        ji_mode;
    logic        clr;
    logic        win;
    logic [7:0]  seg;
    logic [7:0]  an;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [11:0] m_bq;
    logic        m_ji_q;
    int          m_cnt;
    logic [3:0]  m_mask;
    int          m_blink;
    int          m_scan;
    int          m_idx;

    logic [7:0] glyph_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                   8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    int pow10 [4] = '{1, 10, 100, 1000};

    board_display #(
        .SCAN_DIV  (4),
        .BLINK_LEN (16),
        .BLINK_BIT (2)
    ) dut (
        .clk     (clk),
        .rst_sw  (rst_sw),
        .board   (board),
        .ji_mode (ji_mode),
        .clr     (clr),
        .win     (win),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s @%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bq    = '0;
        m_ji_q  = 1'b0;
        m_cnt   = 0;
        m_mask  = '0;
        m_blink = 0;
        m_scan  = 0;
        m_idx   = 0;
    endtask

    // One clock: predict pins from the pre-edge model, advance the model,
    // then compare after the edge.
    task automatic tick();
        logic [7:0] e_an;
        logic [7:0] e_seg;
        int         v;
        logic       blk;
        logic       mv;
        e_an = 8'h01 << m_idx;
        if (m_idx < 4) begin
            v     = int'((m_bq >> (3 * m_idx)) & 12'h7);
            blk   = (v == 0) || (m_mask[m_idx] && (m_blink != 0) && (((m_blink >> 2) & 1) == 1));
            e_seg = blk ? 8'h00 : glyph_tab[v];
            e_seg[7] = win;
        end else begin
            v     = (m_cnt / pow10[m_idx - 4]) % 10;
            e_seg = glyph_tab[v];
        end

        mv = (board != m_bq) && !ji_mode && !m_ji_q && !clr;
        if (clr) begin
            m_cnt   = 0;
            m_mask  = '0;
            m_blink = 0;
        end else if (mv) begin
            if (m_cnt < 9999) m_cnt = m_cnt + 1;
            for (int c = 0; c < 4; c++) m_mask[c] = (board[3*c +: 3] != m_bq[3*c +: 3]);
            m_blink = 15;
        end else if (m_blink > 0) begin
            m_blink = m_blink - 1;
            if (m_blink == 0) m_mask = '0;
        end else begin
            m_mask = '0;
        end
        if (m_scan == 3) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % 8;
        end else begin
            m_scan = m_scan + 1;
        end
        m_bq   = board;
        m_ji_q = ji_mode;

        @(posedge clk);
        #1;
        check("an", an, e_an);
        check("seg", seg, e_seg);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int r;
        rst_sw  = 1'b1;
        board   = '0;
        ji_mode = 1'b0;
        clr     = 1'b0;
        win     = 1'b0;
        model_reset();

        // Reset state: display dark
        @(posedge clk);
        #1;
        check("rst_an", an, 8'h00);
        check("rst_seg", seg, 8'h00);
        @(negedge clk);
        rst_sw = 1'b0;

        $display("step 1: scan after reset release, empty board");
        ticks(40);

        $display("step 2: first move 000 -> 00A, blink then steady");
        board = 12'h00A;
        ticks(48);

        $display("step 3: drive counter to saturation, then clear");
        for (int i = 0; i < 10005; i++) begin
            board = (i % 2 == 0) ? 12'h011 : 12'h022;
            tick();
        end
        ticks(36);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ticks(40);

        $display("step 4: ji_mode entry/exit not counted");
        board = 12'h0A3;
        ticks(8);
        ji_mode = 1'b1;
        board   = 12'h123;
        ticks(3);
        ji_mode = 1'b0;
        board   = 12'h0A3;
        ticks(36);
        board = 12'h0A4;
        ticks(40);

        $display("step 5: clr and board change in the same cycle");
        clr   = 1'b1;
        board = 12'h456;
        tick();
        clr = 1'b0;
        ticks(40);

        $display("step 6: win decimal points");
        win = 1'b1;
        ticks(40);
        win = 1'b0;

        $display("step 7: randomized traffic");
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) board = 12'($urandom);
            if (r >= 95) ji_mode = ~ji_mode;
            clr = ($urandom_range(0, 39) == 0);
            win = 1'($urandom_range(0, 1));
            tick();
        end
        clr     = 1'b0;
        ji_mode = 1'b0;
        win     = 1'b0;
        board   = '0;
        ticks(5);

        $display("step 8: asynchronous reset mid-scan");
        #2;
        rst_sw = 1'b1;
        #1;
        check("async_rst_an", an, 8'h00);
        check("async_rst_seg", seg, 8'h00);
        model_reset();
        @(negedge clk);
        rst_sw = 1'b0;
        ticks(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_display.md
Name: board_display

Overview:
- Downstream consumer of the game top's registered 12-bit board output.
- Drives an 8-digit multiplexed seven-segment display.
  - Digits 0-3 show the four 3-bit board cells.
  - Changed cells blink after each move.
  - Digits 4-7 show a BCD move counter, saturating at 9999.
- Runs on the divided game clock clk, alongside the button-flag and play logic.

Parameters:
SCAN_DIV, 1000, clk cycles each digit is held before advancing to the next (>=2)
BLINK_LEN, 4096, clk cycles changed cells blink after a move (>=2)
BLINK_BIT, 8, bit of blink_cnt that selects the blank phase (< clog2(BLINK_LEN))

Ports:
clk  input  1  game clock
rst_sw  input  1  reset, asynchronous, active-high
board  input  12  board value; cell i = board[3i+2:3i]
ji_mode  input  1  high while the original board is shown; moves are not counted
clr  input  1  single-cycle pulse from the game-reset flag; clears counter and blink
win  input  1  win indication
seg  output  8  segment lines, active-high; seg[0]=a..seg[6]=g, seg[7]=dp
an  output  8  digit enables, active-high, one-hot; an[k] = digit k

Behaviour:
- Reset (async, rst_sw=1) clears all of the following to 0:
  - outputs seg, an (display dark)
  - board_q, ji_q, cnt (4 BCD digits), mask[3:0], blink_cnt, scan_cnt, idx[2:0]
- Change detect: board_q<=board and ji_q<=ji_mode every cycle.
  - move = (board!=board_q) & !ji_mode & !ji_q & !clr.
- Counter on move:
  - BCD increment with ripple carry, digit order ones, tens, hundreds, thousands; 9 rolls to 0 with carry.
  - At 9999 it holds (saturates), no wrap.
- Blink on move:
  - mask <= per-cell (board cell != board_q cell).
  - blink_cnt <= BLINK_LEN-1.
  - A move during an active blink reloads mask (replaced, not OR-ed) and restarts blink_cnt.
- Otherwise blink_cnt decrements while nonzero; mask clears when blink_cnt reaches 0.
- clr has priority over move: cnt<=0, mask<=0, blink_cnt<=0 in the same cycle.
- ji_mode edges (either direction) never count and never blink, because ji_q masks the changed cycle.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On the cycle scan_cnt==SCAN_DIV-1 it wraps to 0 and idx increments, 7 wrapping to 0.
- Output register (every cycle after reset): an<=1<<idx; seg<=pattern(idx).
  - Latency: 1 cycle from idx/state to pins.
  - First post-reset edge gives an=8'h01.
- pattern(idx):
  - idx 0-3: cell value v=board_q cell idx.
    - v==0 gives blank 8'h00.
    - Also blank when mask[idx] & blink_cnt!=0 & blink_cnt[BLINK_BIT]==1.
    - Otherwise the decimal glyph for v.
  - idx 4-7: cnt digit idx-4. Leading zeros are shown.
  - dp (seg[7]) = win for idx 0-3; 0 for idx 4-7.
- Glyphs (hex, bit0=a):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
- clr/board/ji_mode are synchronous to clk; no synchronizers are needed.

Decomposition:
- Shared package (board_disp_pkg):
  - glyph constants SEG_0..SEG_9, SEG_BLANK
  - NUM_DIGITS=8, CELL_W=3, NUM_CELLS=4
- One natural sub-module: seg7_decode, combinational 4-bit value to 7-segment glyph.
- BCD counter and scan/blink logic stay inline.

Test Plan:
Settings: SCAN_DIV=4, BLINK_LEN=16, BLINK_BIT=2.
1. Reset release, board=0 -> an=01 on first edge, advances 01,02,04,...,80,01 every 4 cycles; all digits 0-3 seg=00; digits 4-7 seg=3F.
2. board 12'h000 -> 12'h00A (cell0=2, cell1=1) -> cnt=0001; mask=4'b0011; digit0 alternates 5B/00 and digit1 alternates 06/00 with blink_cnt[2] until 16 cycles elapse, then steady 5B/06.
3. Preload cnt=9999 via 9999 board toggles; one more change -> cnt stays 9999. Then clr pulse -> digits 4-7 all 3F next scan; mask=0.
4. ji_mode=1 with a board change, then ji_mode=0 with the board restored -> cnt unchanged, no blink; a subsequent normal change increments by exactly 1.
5. clr and a board change in the same cycle -> cnt=0000, mask=0; the change is not counted.
6. win=1 -> seg[7]=1 while an[3:0] is active, 0 on an[7:4]; rst_sw asserted mid-scan -> seg=00, an=00 immediately (async), cnt=0.
